// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        OP_UMULL = 2'b00,
        OP_SMULL = 2'b01,
        OP_UDIV  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Fixed-latency shift/add multiplier and restoring divider sharing one
// (WIDTH+1)-bit adder; 32 CALC steps, one FIX step, then a one-cycle Done.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result2,
    output logic             DivByZero
);

    localparam int unsigned AW = WIDTH + 1;

    state_e               state_q;
    op_e                  op_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 zdiv_q;
    logic [WIDTH-1:0]     opb_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     res2_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;

    logic [AW-1:0]        add_a;
    logic [AW-1:0]        add_b;
    logic                 add_cin;
    logic [AW-1:0]        add_sum;
    logic [AW-1:0]        mul_hi;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
    logic [2*WIDTH-1:0]   acc_neg;
    logic                 accept;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    assign accept = Start && (Op != OP_RSVD);

    // Shared adder: hi+multiplicand for multiply, {rem,msb}-divisor for divide
    always_comb begin
        add_a   = {1'b0, hi_q};
        add_b   = {1'b0, opb_q};
        add_cin = 1'b0;
        if (op_q == OP_UDIV) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end
        add_sum = add_a + add_b + AW'(add_cin);
    end

    // One iteration of the accumulator update
    always_comb begin
        mul_hi = lo_q[0] ? add_sum : {1'b0, hi_q};
        hi_d   = mul_hi[WIDTH:1];
        lo_d   = {mul_hi[0], lo_q[WIDTH-1:1]};
        if (op_q == OP_UDIV) begin
            if (!add_sum[WIDTH]) begin
                hi_d = add_sum[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = add_a[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign acc_neg = (2*WIDTH)'(-{hi_q, lo_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_UMULL;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zdiv_q  <= 1'b0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            res2_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        op_q    <= op_e'(Op);
                        cnt_q   <= '0;
                        hi_q    <= '0;
                        neg_q   <= 1'b0;
                        zdiv_q  <= (Op == OP_UDIV) && (SrcB == '0);
                        // lo holds the multiplier or dividend, opb the multiplicand or divisor
                        if (Op == OP_SMULL) begin
                            lo_q  <= mag(SrcB);
                            opb_q <= mag(SrcA);
                            neg_q <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                        end else if (Op == OP_UDIV) begin
                            lo_q  <= SrcA;
                            opb_q <= SrcB;
                        end else begin
                            lo_q  <= SrcB;
                            opb_q <= SrcA;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if ((op_q == OP_SMULL) && neg_q) begin
                        {res2_q, res_q} <= acc_neg;
                    end else begin
                        {res2_q, res_q} <= {hi_q, lo_q};
                    end
                    dbz_q   <= zdiv_q;
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Result    = res_q;
    assign Result2   = res2_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic/latency model plus directed literal checks.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] Result2;
    logic        DivByZero;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Result2   (Result2),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {DivByZero, Result2, Result} straight from the arithmetic definitions
    function automatic logic [64:0] model_calc(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            default: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return {(op == 2'b10) && (b == 32'd0), p};
    endfunction

    // Model: countdown from accept to Done, results published when Done appears
    int          m_rem;
    logic [64:0] m_pend;
    logic [31:0] m_res;
    logic [31:0] m_res2;
    logic        m_dbz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_pend <= '0;
            m_res  <= '0;
            m_res2 <= '0;
            m_dbz  <= 1'b0;
        end else if ((m_rem <= 1) && Start && (Op != 2'b11)) begin
            m_rem  <= 34;
            m_pend <= model_calc(Op, SrcA, SrcB);
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_res  <= m_pend[31:0];
                m_res2 <= m_pend[63:32];
                m_dbz  <= m_pend[64];
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(Busy), 64'(m_rem >= 2));
        check("done", 64'(Done), 64'(m_rem == 1));
        check("result", 64'(Result), 64'(m_res));
        check("result2", 64'(Result2), 64'(m_res2));
        check("dbz", 64'(DivByZero), 64'(m_dbz));
    end

    // Starts at the first negedge after accept (n=1); optional Start pulse at n==pulse_at
    task automatic wait_done(input int pulse_at, output int n);
        n = 1;
        while ((n <= 60) && !Done) begin
            if (n == pulse_at) begin
                Start = 1'b1;
                Op    = 2'b00;
            end else if (n == pulse_at + 1) begin
                Start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at, input logic [31:0] er,
                          input logic [31:0] er2, input logic edbz);
        int n;
        @(negedge clk);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
        SrcA  = $urandom;
        SrcB  = $urandom;
        wait_done(pulse_at, n);
        check({name, "_latency"}, 64'(n), 64'd34);
        check({name, "_res"}, 64'(Result), 64'(er));
        check({name, "_res2"}, 64'(Result2), 64'(er2));
        check({name, "_dbz"}, 64'(DivByZero), 64'(edbz));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        SrcA  = '0;
        SrcB  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_res", 64'({Result2, Result}), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op("umull_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("smull_m2x3", 2'b01, 32'hFFFF_FFFE, 32'd3, -10, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0);
        run_op("smull_min", 2'b01, 32'h8000_0000, 32'h8000_0000, -10, 32'h0, 32'h4000_0000, 1'b0);
        run_op("smull_7xm3", 2'b01, 32'd7, 32'hFFFF_FFFD, -10, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
        run_op("udiv_100_7", 2'b10, 32'd100, 32'd7, -10, 32'd14, 32'd2, 1'b0);
        run_op("udiv_5_0", 2'b10, 32'd5, 32'd0, 5, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("udiv_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 12, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Back-to-back: Start held high through the first operation's DONE
        @(negedge clk);
        Start = 1'b1;
        Op    = 2'b10;
        SrcA  = 32'd100;
        SrcB  = 32'd7;
        @(negedge clk);
        Op   = 2'b00;
        SrcA = 32'd3;
        SrcB = 32'd4;
        wait_done(-10, n);
        check("b2b1_latency", 64'(n), 64'd34);
        check("b2b1_res", 64'(Result), 64'd14);
        check("b2b1_res2", 64'(Result2), 64'd2);
        @(negedge clk);
        check("b2b_no_gap_busy", 64'(Busy), 64'd1);
        check("b2b_no_gap_done", 64'(Done), 64'd0);
        Start = 1'b0;
        SrcA  = $urandom;
        wait_done(-10, n);
        check("b2b2_latency", 64'(n), 64'd34);
        check("b2b2_res", 64'(Result), 64'd12);
        check("b2b2_res2", 64'(Result2), 64'd0);

        // Reserved op must be ignored
        @(negedge clk);
        Start = 1'b1;
        Op    = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("rsvd_busy", 64'(Busy), 64'd0);
            check("rsvd_done", 64'(Done), 64'd0);
        end
        Start = 1'b0;

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        Start = 1'b1;
        Op    = 2'b00;
        SrcA  = 32'h1234_5678;
        SrcB  = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(Busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        check("arst_res", 64'(Result), 64'd0);
        check("arst_res2", 64'(Result2), 64'd0);
        check("arst_dbz", 64'(DivByZero), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        run_op("umull_6x7", 2'b00, 32'd6, 32'd7, -10, 32'd42, 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that takes the long-multiply (UMULL, SMULL) and UDIV operations off the single-cycle ALU path. It sits beside the ALU in the multicycle datapath and is started by the main control FSM, which holds in its execute state until `Done`. One shared 33-bit add/subtract unit runs a fixed 32-step schedule. The latency is the same for every operation.

## Interface
- `WIDTH`, default 32: operand width. The RTL is written generically, but only 32 is verified.
- `clk` in, 1 bit: the only clock; everything is rising-edge.
- `reset` in, 1 bit: asynchronous, active-high; clears all state.
- `Start` in, 1 bit: request. It is sampled on a rising edge of `clk` only in IDLE or DONE.
- `Op` in, 2 bits: operation select.
  - 00: UMULL.
  - 01: SMULL.
  - 10: UDIV.
  - 11: reserved. `Start` is ignored and the block stays in IDLE.
- `SrcA` in, WIDTH bits: multiplicand or dividend. Captured only when `Start` is accepted.
- `SrcB` in, WIDTH bits: multiplier or divisor. Captured only when `Start` is accepted.
- `Busy` out, 1 bit: high in CALC and FIX.
- `Done` out, 1 bit: one-cycle pulse in DONE; results are valid from this cycle.
- `Result` out, WIDTH bits: product bits [31:0] for multiplies, quotient for UDIV.
- `Result2` out, WIDTH bits: product bits [63:32] for multiplies, remainder for UDIV.
- `DivByZero` out, 1 bit: high with `Done` when `Op`=10 and `SrcB`=0. It is 0 for every other operation.

## Operation
- FSM states are IDLE, CALC, FIX and DONE. Transitions:
  - IDLE → CALC when `Start` is high and `Op`≠11.
  - CALC → FIX when the iteration counter reaches 31.
  - FIX → DONE unconditionally.
  - DONE → CALC when a new valid `Start` arrives (back-to-back operation); otherwise DONE → IDLE.
- On accept:
  - Latch `Op` and clear the 5-bit counter.
  - For SMULL, latch operand magnitudes and the result sign A[31]^B[31]. The magnitude of 0x80000000 is 2^31, which fits in an unsigned 32-bit value.
  - For UMULL and UDIV, latch the raw operands.
- Multiply: 64-bit accumulator {hi, lo}, with lo loaded with the multiplier. On each CALC cycle, if lo[0] is 1, hi+multiplicand (33-bit with carry) replaces hi. The whole accumulator then shifts right by 1 with the carry entering bit 63.
- Divide, restoring: {rem, quo}, with quo loaded with the dividend and rem with 0. On each CALC cycle:
  - Shift left 1.
  - Compute the trial value rem−divisor in 33 bits.
  - If it is non-negative, rem takes the difference and quo[0] is set to 1.
- Divide by zero follows naturally from the algorithm with no special-casing: quotient 0xFFFFFFFF, remainder `SrcA`. `DivByZero` is registered from the latched divisor==0 condition.
- FIX:
  - For SMULL with the sign bit set, the 64-bit two's-complement negation of the accumulator is written to `Result2`:`Result`.
  - Otherwise the accumulator is copied unchanged.
- `Result`, `Result2` and `DivByZero` are updated only in FIX and hold until the next FIX. `Start` and `Op` seen in CALC or FIX are ignored: no queuing and no abort.
- The operand inputs may change freely after the accept edge.

## Timing
- Reset values: state IDLE, counter 0, `Busy`=0, `Done`=0, `Result`=0, `Result2`=0, `DivByZero`=0.
- Accept edge is t0.
  - CALC occupies cycles t0+1..t0+32.
  - FIX is cycle t0+33.
  - DONE (`Done`=1, results valid) is cycle t0+34.
- Every operation has a fixed latency of 34 cycles from accept to `Done`.
- Back-to-back: a `Start` sampled in DONE is accepted on that edge. `Done` is high for exactly one cycle, and the next CALC begins at once with no idle gap.
- `reset` asserted in any state forces the reset values immediately (asynchronous). Any partial result is discarded and `Done` is not produced. After release, the block waits in IDLE.
- All outputs are registered; none depend combinationally on the inputs.

## Structure
- Package `muldiv_pkg` holds:
  - the `Op` encodings (OP_UMULL, OP_SMULL, OP_UDIV, OP_RSVD);
  - the state enum;
  - `ITERATIONS`=32 and the counter width.
- Single module with no sub-module. The one 33-bit adder is shared between the multiply add and the divide trial-subtract, with the operand and carry-in selected by the latched op.

## Test plan
- UMULL 0xFFFFFFFF×0xFFFFFFFF → `Result2`=0xFFFFFFFE, `Result`=0x00000001, with `Done` exactly 34 cycles after accept.
- SMULL −2 (0xFFFFFFFE)×3 → 0xFFFFFFFF_FFFFFFFA. SMULL 0x80000000×0x80000000 → `Result2`=0x40000000, `Result`=0.
- UDIV 100/7 → `Result`=14, `Result2`=2, `DivByZero`=0. UDIV 5/0 → 0xFFFFFFFF, remainder 5, `DivByZero`=1.
- Back-to-back sequence:
  - Hold `Start` high through DONE with UDIV 100/7 followed by UMULL 3×4.
  - Required: no idle cycle between the two operations.
  - Second result is `Result`=12, `Result2`=0.
  - `Start` pulses during CALC are ignored.
- `Op`=11 with `Start` → `Busy` stays 0 and no `Done`.
- `reset` asserted at CALC cycle 10 → all outputs are 0 immediately. A subsequent 6×7 UMULL completes correctly (`Result`=42).
